// File: rtl/audio_pkg.sv
// Shared widths, sample types and saturation helpers for the audio mix path.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int MIX_W    = 18;
  localparam int VOL_W    = 5;
  localparam int VOL_MAX  = 16;
  localparam int PROD_W   = 23;
  localparam int SHIFT_W  = PROD_W - 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [MIX_W-1:0]    mix_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [SHIFT_W-1:0]  scaled_t;

  localparam scaled_t POS_LIM = 19'sd32767;
  localparam scaled_t NEG_LIM = -19'sd32768;

  function automatic logic is_clipped(input scaled_t x);
    return (x > POS_LIM) || (x < NEG_LIM);
  endfunction

  function automatic sample_t saturate16(input scaled_t x);
    sample_t r;
    if (x > POS_LIM) begin
      r = 16'sh7fff;
    end else if (x < NEG_LIM) begin
      r = 16'sh8000;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/audio_rate_gen.sv
// Fractional phase accumulator producing one registered tick per output sample
// period; spacing alternates between floor and ceil of CLK_HZ/SAMPLE_HZ.
module audio_rate_gen #(
  parameter int CLK_HZ    = 14318180,
  parameter int SAMPLE_HZ = 48000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int ACC_W = $clog2(CLK_HZ + SAMPLE_HZ);
  localparam logic [ACC_W-1:0] STEP = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic             wrap_s;
  logic             tick_r;

  assign sum_s  = acc_r + STEP;
  assign wrap_s = (sum_s >= WRAP);
  assign tick   = tick_r;

  // Phase accumulation with remainder carry keeps the long-term rate exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      acc_r  <= wrap_s ? (sum_s - WRAP) : sum_s;
      tick_r <= wrap_s;
    end
  end
endmodule

// File: rtl/audio_mix_decimator.sv
// Mixes DOC PCM with a decaying Apple II speaker step, applies a ramped master
// volume with saturation, and decimates to SAMPLE_HZ with a one-cycle strobe.
module audio_mix_decimator
  import audio_pkg::*;
#(
  parameter int CLK_HZ            = 14318180,
  parameter int SAMPLE_HZ         = 48000,
  parameter int SPK_AMP           = 8192,
  parameter int DECAY_PERIOD_LOG2 = 10,
  parameter int RAMP_PERIOD_LOG2  = 10
) (
  input  logic        CLK_14M,
  input  logic        reset_n,
  input  logic [15:0] doc_in,
  input  logic        doc_valid,
  input  logic        speaker_state,
  input  logic [4:0]  vol,
  input  logic        mute,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_strobe,
  output logic        clip
);
  localparam sample_t SPK_POS = sample_t'(SPK_AMP);
  localparam sample_t SPK_NEG = sample_t'(-SPK_AMP);
  localparam logic [VOL_W-1:0] VOL_TOP = VOL_W'(VOL_MAX);

  sample_t doc_hold_r, spk_level_r, spk_next_s, spk_decay_s, s3_r, out_sample_r;
  logic    spk_prev_r, edge_s, decay_tick_s, ramp_tick_s, spk_small_s, rate_tick_s;
  logic [DECAY_PERIOD_LOG2-1:0] decay_cnt_r;
  logic [RAMP_PERIOD_LOG2-1:0]  ramp_cnt_r;
  logic [VOL_W-1:0] vol_eff_r, vol_tgt_s, vol_next_s;
  mix_t    s1_r;
  prod_t   s2_r, s1_ext_s, vol_ext_s;
  scaled_t scaled_s;
  logic    s3_sat_r, clip_pend_r, strobe_r, clip_r;

  assign edge_s       = speaker_state ^ spk_prev_r;
  assign decay_tick_s = &decay_cnt_r;
  assign ramp_tick_s  = &ramp_cnt_r;
  assign spk_small_s  = (spk_level_r > -16'sd16) && (spk_level_r < 16'sd16);
  assign spk_decay_s  = spk_level_r - (spk_level_r >>> 4);

  // Speaker level: a toggle re-arms the full step and takes priority over decay.
  always_comb begin
    spk_next_s = spk_level_r;
    if (edge_s) begin
      spk_next_s = speaker_state ? SPK_POS : SPK_NEG;
    end else if (decay_tick_s) begin
      spk_next_s = spk_small_s ? 16'sd0 : spk_decay_s;
    end else begin
      spk_next_s = spk_level_r;
    end
  end

  // Volume target and one-step ramp toward it for click-free changes.
  always_comb begin
    vol_tgt_s  = 5'd0;
    vol_next_s = vol_eff_r;
    if (mute) begin
      vol_tgt_s = 5'd0;
    end else if (vol > VOL_TOP) begin
      vol_tgt_s = VOL_TOP;
    end else begin
      vol_tgt_s = vol;
    end
    if (!ramp_tick_s) begin
      vol_next_s = vol_eff_r;
    end else if (vol_eff_r < vol_tgt_s) begin
      vol_next_s = vol_eff_r + 5'd1;
    end else if (vol_eff_r > vol_tgt_s) begin
      vol_next_s = vol_eff_r - 5'd1;
    end else begin
      vol_next_s = vol_eff_r;
    end
  end

  // Input capture, speaker state, free-running timers and effective volume.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      doc_hold_r  <= 16'sd0;
      spk_prev_r  <= 1'b0;
      spk_level_r <= 16'sd0;
      decay_cnt_r <= '0;
      ramp_cnt_r  <= '0;
      vol_eff_r   <= 5'd0;
    end else begin
      if (doc_valid) begin
        doc_hold_r <= doc_in;
      end else begin
        doc_hold_r <= doc_hold_r;
      end
      spk_prev_r  <= speaker_state;
      spk_level_r <= spk_next_s;
      decay_cnt_r <= edge_s ? '0 : decay_cnt_r + DECAY_PERIOD_LOG2'(1);
      ramp_cnt_r  <= ramp_cnt_r + RAMP_PERIOD_LOG2'(1);
      vol_eff_r   <= vol_next_s;
    end
  end

  // Dropping the low 4 product bits is the >>>4 that undoes the 0..16 gain scale.
  assign s1_ext_s  = prod_t'(s1_r);
  assign vol_ext_s = prod_t'(vol_eff_r);
  assign scaled_s  = s2_r[PROD_W-1:4];

  // Three-stage mix: sum, gain, saturate.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      s1_r     <= 18'sd0;
      s2_r     <= 23'sd0;
      s3_r     <= 16'sd0;
      s3_sat_r <= 1'b0;
    end else begin
      s1_r     <= mix_t'(doc_hold_r) + mix_t'(spk_level_r);
      s2_r     <= s1_ext_s * vol_ext_s;
      s3_r     <= saturate16(scaled_s);
      s3_sat_r <= is_clipped(scaled_s);
    end
  end

  audio_rate_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_rate (
    .clk    (CLK_14M),
    .reset_n(reset_n),
    .tick   (rate_tick_s)
  );

  // Output sample register; clip reports any saturation since the last strobe.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      out_sample_r <= 16'sd0;
      strobe_r     <= 1'b0;
      clip_r       <= 1'b0;
      clip_pend_r  <= 1'b0;
    end else if (rate_tick_s) begin
      out_sample_r <= s3_r;
      strobe_r     <= 1'b1;
      clip_r       <= clip_pend_r | s3_sat_r;
      clip_pend_r  <= 1'b0;
    end else begin
      out_sample_r <= out_sample_r;
      strobe_r     <= 1'b0;
      clip_r       <= 1'b0;
      clip_pend_r  <= clip_pend_r | s3_sat_r;
    end
  end

  assign audio_l       = out_sample_r;
  assign audio_r       = out_sample_r;
  assign sample_strobe = strobe_r;
  assign clip          = clip_r;
endmodule
